// File: rtl/tff_counter_if.sv
// tff_counter_if: control and state bundle for the tff_counter toggle/count bank
interface tff_counter_if #(parameter int WIDTH = 4);
  logic             preset;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             wrap;
  modport master (output preset, en, mode, t, input q, qbar, wrap);
  modport slave  (input preset, en, mode, t, output q, qbar, wrap);
endinterface

// File: rtl/tff_counter.sv
// tff_counter: WIDTH-bit T flip-flop bank usable as toggle cells or a wrapping/saturating up/down counter
module tff_counter #(
  parameter int               WIDTH        = 4,
  parameter logic [WIDTH-1:0] PRESET_VALUE = {WIDTH{1'b1}},
  parameter bit               SATURATE     = 1'b0
) (
  input logic           clk,
  input logic           clear,
  tff_counter_if.slave  bus
);
  localparam logic [1:0] M_TOG  = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DN   = 2'b10;
  logic [WIDTH-1:0] q, q_nxt, up_t, dn_t, tog;
  logic             wrap, wrap_nxt, at_max, at_min;
  // Ripple-carry toggle masks: q^(q+1) is exactly the AND-of-lower-bits chain, q^(q-1) its qbar dual
  assign up_t   = q ^ (q + WIDTH'(1));
  assign dn_t   = q ^ (q - WIDTH'(1));
  assign at_max = &q;
  assign at_min = ~|q;
  always_comb begin
    tog      = bus.mode == M_TOG ? bus.t
             : bus.mode == M_UP  ? (SATURATE && at_max ? '0 : up_t)
             : bus.mode == M_DN  ? (SATURATE && at_min ? '0 : dn_t)
             : '0;
    q_nxt    = bus.preset ? PRESET_VALUE : bus.en ? q ^ tog : q;
    wrap_nxt = !bus.preset && bus.en &&
               ((bus.mode == M_UP && at_max) || (bus.mode == M_DN && at_min));
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      q    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= q_nxt;
      wrap <= wrap_nxt;
    end
  end
  assign bus.q    = q;
  assign bus.qbar = ~q;
  assign bus.wrap = wrap;
endmodule

// File: doc/tff_counter.md
Name: tff_counter

Overview:
- Parametrised successor to the single-bit T flip-flop: a WIDTH-bit bank of T flip-flops with a shared clock.
- Operates either as independent per-bit toggle cells or as a synchronous up/down counter built from the same toggle cells.
- Provides preset and clear, optional saturation, and a registered wrap/saturate event flag.
- Used as the general toggle/count primitive for Basys3 designs such as dividers, LED sequencers and debouncer timers.

Parameters:
- WIDTH, 4, number of T flip-flop bits (1..32).
- PRESET_VALUE, {WIDTH{1'b1}}, value loaded by preset.
- SATURATE, 0, 0 = counter wraps at the limit; 1 = counter holds at max (up) or 0 (down).

Ports:
- clk  input  1  rising-edge clock.
- clear  input  1  asynchronous reset, active-low; forces q to 0.
- preset  input  1  synchronous, active-high; loads PRESET_VALUE.
- en  input  1  synchronous enable for toggle and count modes.
- mode  input  2  00 = toggle, 01 = count up, 10 = count down, 11 = hold.
- t  input  WIDTH  per-bit toggle inputs; used only in toggle mode.
- q  output  WIDTH  flip-flop state.
- qbar  output  WIDTH  bitwise complement of q, combinational from q.
- wrap  output  1  registered one-cycle pulse on a wrap or saturation event.

Behaviour:
- Reset: clear low forces q = 0 and wrap = 0 immediately, independent of clk, so qbar = all ones.
  - State is held while clear is low; all synchronous inputs are ignored.
  - On clear deassertion, the first active edge evaluates normally.
  - Asserting clear mid-count aborts the count and drops any pending wrap.
- Priority at each rising edge: clear (async) > preset > en = 0 / hold > mode operation.
- preset = 1: q <= PRESET_VALUE and wrap <= 0, regardless of en or mode.
- en = 0 or mode = 11: q holds and wrap <= 0.
- Toggle mode (00), en = 1: q <= q ^ t.
  - t = 0 leaves q unchanged.
  - wrap <= 0 always in this mode.
- Count up (01), en = 1: each bit's toggle input is the AND of all lower q bits (bit 0 toggle = 1).
  - Equivalent result: q <= q + 1 modulo 2^WIDTH.
  - At q = all ones with SATURATE = 0: q <= 0 and wrap <= 1.
  - At q = all ones with SATURATE = 1: q holds and wrap <= 1 on every enabled cycle spent at the limit.
- Count down (10), en = 1: each bit's toggle input is the AND of all lower qbar bits.
  - Equivalent result: q <= q - 1 modulo 2^WIDTH.
  - At q = 0 with SATURATE = 0: q <= all ones and wrap <= 1.
  - At q = 0 with SATURATE = 1: q holds at 0 and wrap <= 1.
- Latency: q changes one clock after the sampled inputs; wrap is asserted in the same cycle as the q update it describes.
- Mode changes take effect on the next edge with no dead cycle; an up→down switch at max does not flag wrap.
- t is ignored in count modes; all X/undefined t is ignored outside toggle mode.
- WIDTH = 1: count up and count down both toggle q every enabled cycle, and wrap fires on each 1→0 (up) or 0→1 (down) transition.

Test Plan:
All scenarios use WIDTH = 4 and SATURATE = 0 unless stated.
- Reset: drive clear = 0 asynchronously mid-cycle with q = 9 → q = 0 and qbar = 15 before the next edge; hold clear low for 3 edges → q stays 0.
- Preset priority: preset = 1, en = 1, mode = 01, q = 3 → next edge q = 15, wrap = 0; release preset → next edge q = 0, wrap = 1.
- Toggle: mode = 00, en = 1, t = 4'b0101 from q = 0 → q sequence 5, 0, 5; then t = 0 → q held; en = 0 with t = 4'b1111 → q held.
- Up wrap: count up from 13 for 4 edges → q = 14, 15, 0, 1 with wrap high only on the 15→0 edge.
- Down wrap: count down from 1 for 3 edges → q = 0, 15, 14 with wrap high only on the 0→15 edge; mode = 11 → q holds at 14.
- Saturate (SATURATE = 1): count up from 14 → q = 15, 15, 15 with wrap = 0, 1, 1; switch to count down → q = 14 with wrap = 0.
